// File: rtl/proc_mem_responder.sv
// proc_mem_responder: single-port memory end of the processor's val/rdy
// request/response streams. Holds one outstanding request, answers it after
// a fixed latency, supports byte-granular reads/writes and echoes the opaque.
module proc_mem_responder #(
    parameter int p_num_words    = 256,
    parameter int p_latency      = 1,
    parameter int p_opaque_nbits = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      reqstream_val,
    output logic                      reqstream_rdy,
    input  logic [2:0]                reqstream_type,
    input  logic [p_opaque_nbits-1:0] reqstream_opaque,
    input  logic [31:0]               reqstream_addr,
    input  logic [1:0]                reqstream_len,
    input  logic [31:0]               reqstream_data,

    output logic                      respstream_val,
    input  logic                      respstream_rdy,
    output logic [2:0]                respstream_type,
    output logic [p_opaque_nbits-1:0] respstream_opaque,
    output logic [1:0]                respstream_test,
    output logic [1:0]                respstream_len,
    output logic [31:0]               respstream_data
);

    localparam int c_idx_nbits = $clog2(p_num_words);
    localparam int c_cnt_nbits = (p_latency > 1) ? $clog2(p_latency) : 1;
    localparam logic [c_cnt_nbits-1:0] c_cnt_load = c_cnt_nbits'(p_latency - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t state;
    state_t state_next;

    logic [c_cnt_nbits-1:0]  count;
    logic [31:0]             mem [p_num_words];

    logic                    accept;
    logic [c_idx_nbits-1:0]  word_idx;
    logic [1:0]              offset;
    logic                    in_range;
    logic                    is_read;
    logic                    is_write;
    logic [2:0]              nbytes;
    logic [31:0]             len_mask;
    logic [31:0]             rd_shifted;
    logic [31:0]             wr_shifted;
    logic [3:0]              byte_en;
    logic [1:0]              test_next;
    logic [31:0]             data_next;

    assign accept   = reqstream_val && reqstream_rdy;
    assign word_idx = reqstream_addr[c_idx_nbits+1:2];
    assign offset   = reqstream_addr[1:0];
    assign in_range = (reqstream_addr[31:c_idx_nbits+2] == '0);
    assign is_read  = (reqstream_type == 3'd0);
    assign is_write = (reqstream_type == 3'd1);

    // Decode the request: byte count, read alignment/mask, write byte lanes, status.
    always_comb begin
        nbytes     = (reqstream_len == 2'd0) ? 3'd4 : {1'b0, reqstream_len};
        len_mask   = 32'hFFFF_FFFF;
        rd_shifted = mem[word_idx] >> {offset, 3'b000};
        wr_shifted = reqstream_data << {offset, 3'b000};
        byte_en    = '0;
        test_next  = 2'd0;
        data_next  = '0;

        case (reqstream_len)
            2'd1:    len_mask = 32'h0000_00FF;
            2'd2:    len_mask = 32'h0000_FFFF;
            2'd3:    len_mask = 32'h00FF_FFFF;
            default: len_mask = 32'hFFFF_FFFF;
        endcase

        for (int j = 0; j < 4; j++) begin
            byte_en[j] = (j >= int'(offset)) && ((j - int'(offset)) < int'(nbytes));
        end

        if (!is_read && !is_write) begin
            test_next = 2'd2;
        end else if (!in_range) begin
            test_next = 2'd1;
        end else if (is_read) begin
            data_next = rd_shifted & len_mask;
        end
    end

    // Storage array: byte-lane write at accept; contents survive reset.
    always_ff @(posedge clk) begin
        if (reset && accept && is_write && in_range) begin
            for (int j = 0; j < 4; j++) begin
                if (byte_en[j]) begin
                    mem[word_idx][8*j +: 8] <= wr_shifted[8*j +: 8];
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next     = state;
        reqstream_rdy  = 1'b0;
        respstream_val = 1'b0;
        case (state)
            IDLE: begin
                reqstream_rdy = 1'b1;
                if (reqstream_val) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    respstream_val = 1'b1;
                    if (respstream_rdy) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latency counter: loaded at accept, counts down to the response cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (accept) begin
            count <= c_cnt_load;
        end else if (state == BUSY && count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Response registers: captured at accept and held until the handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            respstream_type   <= '0;
            respstream_opaque <= '0;
            respstream_test   <= '0;
            respstream_len    <= '0;
            respstream_data   <= '0;
        end else if (accept) begin
            respstream_type   <= reqstream_type;
            respstream_opaque <= reqstream_opaque;
            respstream_test   <= test_next;
            respstream_len    <= reqstream_len;
            respstream_data   <= data_next;
        end
    end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Directed self-checking bench for proc_mem_responder (latency 3, 256 words).
module tb_proc_mem_responder;

    localparam int c_lat = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        reqstream_val;
    logic        reqstream_rdy;
    logic [2:0]  reqstream_type;
    logic [7:0]  reqstream_opaque;
    logic [31:0] reqstream_addr;
    logic [1:0]  reqstream_len;
    logic [31:0] reqstream_data;
    logic        respstream_val;
    logic        respstream_rdy;
    logic [2:0]  respstream_type;
    logic [7:0]  respstream_opaque;
    logic [1:0]  respstream_test;
    logic [1:0]  respstream_len;
    logic [31:0] respstream_data;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    proc_mem_responder #(
        .p_num_words    (256),
        .p_latency      (c_lat),
        .p_opaque_nbits (8)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .reqstream_val     (reqstream_val),
        .reqstream_rdy     (reqstream_rdy),
        .reqstream_type    (reqstream_type),
        .reqstream_opaque  (reqstream_opaque),
        .reqstream_addr    (reqstream_addr),
        .reqstream_len     (reqstream_len),
        .reqstream_data    (reqstream_data),
        .respstream_val    (respstream_val),
        .respstream_rdy    (respstream_rdy),
        .respstream_type   (respstream_type),
        .respstream_opaque (respstream_opaque),
        .respstream_test   (respstream_test),
        .respstream_len    (respstream_len),
        .respstream_data   (respstream_data)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle counter used to measure accept spacing.
    always @(posedge clk) cyc <= cyc + 1;

    // Safety net in case a wait is never satisfied.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic applyStimulus(input logic [2:0] t, input logic [7:0] op,
                                 input logic [31:0] a, input logic [1:0] l,
                                 input logic [31:0] d);
        reqstream_val    = 1'b1;
        reqstream_type   = t;
        reqstream_opaque = op;
        reqstream_addr   = a;
        reqstream_len    = l;
        reqstream_data   = d;
        @(posedge clk);
        @(negedge clk);
        reqstream_val    = 1'b0;
    endtask

    task automatic waitResp(input string tag);
        int n;
        n = 1;
        while (!respstream_val && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_latency"}, n, c_lat);
    endtask

    task automatic doTxn(input string tag, input logic [2:0] t, input logic [7:0] op,
                         input logic [31:0] a, input logic [1:0] l, input logic [31:0] d,
                         input logic [1:0] exp_test, input logic [31:0] exp_data);
        respstream_rdy = 1'b1;
        checkOutput({tag, "_req_rdy"}, reqstream_rdy, 1);
        applyStimulus(t, op, a, l, d);
        waitResp(tag);
        checkOutput({tag, "_type"}, respstream_type, t);
        checkOutput({tag, "_opaque"}, respstream_opaque, op);
        checkOutput({tag, "_test"}, respstream_test, exp_test);
        checkOutput({tag, "_len"}, respstream_len, l);
        checkOutput({tag, "_data"}, respstream_data, exp_data);
        @(negedge clk);
        checkOutput({tag, "_idle_rdy"}, reqstream_rdy, 1);
        checkOutput({tag, "_idle_val"}, respstream_val, 0);
    endtask

    // Directed sequence of all scenarios.
    initial begin
        int n_acc;
        int n_resp;
        int acc_cyc [3];

        reset            = 1'b0;
        reqstream_val    = 1'b0;
        reqstream_type   = '0;
        reqstream_opaque = '0;
        reqstream_addr   = '0;
        reqstream_len    = '0;
        reqstream_data   = '0;
        respstream_rdy   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_req_rdy", reqstream_rdy, 1);
        checkOutput("reset_resp_val", respstream_val, 0);
        checkOutput("reset_resp_data", respstream_data, 0);
        checkOutput("reset_resp_opaque", respstream_opaque, 0);
        checkOutput("reset_resp_test", respstream_test, 0);
        reset = 1'b1;
        @(negedge clk);

        // Full-word write then read back.
        doTxn("wr_full", 3'd1, 8'h05, 32'h10, 2'd0, 32'hDEADBEEF, 2'd0, 32'h0);
        doTxn("rd_full", 3'd0, 8'h06, 32'h10, 2'd0, 32'h0, 2'd0, 32'hDEADBEEF);

        // Subword writes and reads.
        doTxn("wr_base", 3'd1, 8'h07, 32'h10, 2'd0, 32'h11223344, 2'd0, 32'h0);
        doTxn("wr_byte", 3'd1, 8'h08, 32'h11, 2'd1, 32'h000000AB, 2'd0, 32'h0);
        doTxn("rd_word", 3'd0, 8'h09, 32'h10, 2'd0, 32'h0, 2'd0, 32'h1122AB44);
        doTxn("rd_half", 3'd0, 8'h0A, 32'h12, 2'd2, 32'h0, 2'd0, 32'h00001122);
        doTxn("rd_3byte", 3'd0, 8'h0B, 32'h11, 2'd3, 32'h0, 2'd0, 32'h001122AB);
        doTxn("wr_cross", 3'd1, 8'h0C, 32'h13, 2'd0, 32'h998877CC, 2'd0, 32'h0);
        doTxn("rd_after_cross", 3'd0, 8'h0D, 32'h10, 2'd0, 32'h0, 2'd0, 32'hCC22AB44);
        doTxn("rd_cross", 3'd0, 8'h0E, 32'h12, 2'd0, 32'h0, 2'd0, 32'h0000CC22);

        // Stalled response: outputs hold, requests ignored.
        respstream_rdy = 1'b0;
        applyStimulus(3'd0, 8'h30, 32'h10, 2'd0, 32'h0);
        waitResp("stall");
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_val", respstream_val, 1);
            checkOutput("stall_data", respstream_data, 32'hCC22AB44);
            checkOutput("stall_opaque", respstream_opaque, 8'h30);
            checkOutput("stall_req_rdy", reqstream_rdy, 0);
            reqstream_val    = 1'b1;
            reqstream_type   = 3'd1;
            reqstream_opaque = 8'h31;
            reqstream_addr   = 32'h10;
            reqstream_len    = 2'd0;
            reqstream_data   = 32'h0;
            @(negedge clk);
        end
        reqstream_val  = 1'b0;
        respstream_rdy = 1'b1;
        @(negedge clk);
        checkOutput("stall_release_rdy", reqstream_rdy, 1);
        checkOutput("stall_release_val", respstream_val, 0);
        doTxn("rd_after_stall", 3'd0, 8'h32, 32'h10, 2'd0, 32'h0, 2'd0, 32'hCC22AB44);

        // Address range boundaries.
        doTxn("wr_word0", 3'd1, 8'h20, 32'h0, 2'd0, 32'h0BADF00D, 2'd0, 32'h0);
        doTxn("rd_oor", 3'd0, 8'h21, 32'h400, 2'd0, 32'h0, 2'd1, 32'h0);
        doTxn("wr_oor", 3'd1, 8'h22, 32'h400, 2'd0, 32'h12345678, 2'd1, 32'h0);
        doTxn("rd_word0", 3'd0, 8'h23, 32'h0, 2'd0, 32'h0, 2'd0, 32'h0BADF00D);
        doTxn("wr_last", 3'd1, 8'h24, 32'h3FC, 2'd0, 32'hCAFEF00D, 2'd0, 32'h0);
        doTxn("rd_last", 3'd0, 8'h25, 32'h3FC, 2'd0, 32'h0, 2'd0, 32'hCAFEF00D);

        // Reserved type: no access, status 2.
        doTxn("reserved", 3'd3, 8'h26, 32'h10, 2'd0, 32'hFFFFFFFF, 2'd2, 32'h0);
        doTxn("rd_after_rsvd", 3'd0, 8'h27, 32'h10, 2'd0, 32'h0, 2'd0, 32'hCC22AB44);

        // Reset while busy discards the response but keeps the write.
        respstream_rdy = 1'b1;
        applyStimulus(3'd1, 8'h40, 32'h20, 2'd0, 32'h5A5A5A5A);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("busy_reset_val", respstream_val, 0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("busy_reset_rdy", reqstream_rdy, 1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("busy_reset_no_val", respstream_val, 0);
            @(negedge clk);
        end
        doTxn("rd_after_reset", 3'd0, 8'h41, 32'h20, 2'd0, 32'h0, 2'd0, 32'h5A5A5A5A);

        // Back-to-back reads with request valid held high.
        respstream_rdy   = 1'b1;
        reqstream_type   = 3'd0;
        reqstream_addr   = 32'h10;
        reqstream_len    = 2'd0;
        reqstream_data   = 32'h0;
        reqstream_val    = 1'b1;
        n_acc  = 0;
        n_resp = 0;
        for (int k = 0; k < 60 && n_resp < 3; k++) begin
            if (respstream_val) begin
                checkOutput("b2b_opaque", respstream_opaque, 32'h80 + n_resp);
                checkOutput("b2b_data", respstream_data, 32'hCC22AB44);
                n_resp++;
            end
            if (reqstream_rdy && n_acc < 3) begin
                reqstream_opaque = 8'(8'h80 + n_acc);
                acc_cyc[n_acc]   = cyc;
                n_acc++;
            end else if (n_acc >= 3) begin
                reqstream_val = 1'b0;
            end
            @(negedge clk);
        end
        reqstream_val = 1'b0;
        checkOutput("b2b_accepts", n_acc, 3);
        checkOutput("b2b_resps", n_resp, 3);
        checkOutput("b2b_spacing0", acc_cyc[1] - acc_cyc[0], c_lat + 1);
        checkOutput("b2b_spacing1", acc_cyc[2] - acc_cyc[1], c_lat + 1);
        checkOutput("b2b_idle_rdy", reqstream_rdy, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
Single-port data/instruction memory responder that serves the processor's val/rdy memory request stream and returns responses after a fixed, parameterised latency. It holds a word-addressed storage array, performs reads and byte-granular writes, and echoes the opaque field. Tests and the simulation harness use it as the memory end of the processor's imem/dmem ports.

Parameters:
p_num_words, 256, number of 32-bit words in the storage array (power of two, >=4)
p_latency, 1, cycles from request accept to first response-valid cycle (>=1)
p_opaque_nbits, 8, width of the opaque tag field

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous reset, active-low (asserted when 0)
reqstream_val  input  1  request valid
reqstream_rdy  output  1  responder can accept a request
reqstream_type  input  3  0 = read, 1 = write, others reserved
reqstream_opaque  input  p_opaque_nbits  tag, echoed in response
reqstream_addr  input  32  byte address
reqstream_len  input  2  bytes to access; 0 encodes 4
reqstream_data  input  32  write data, right-justified
respstream_val  output  1  response valid
respstream_rdy  input  1  consumer can accept response
respstream_type  output  3  copy of request type
respstream_opaque  output  p_opaque_nbits  copy of request opaque
respstream_test  output  2  0 = ok, 1 = out of range, 2 = reserved type
respstream_len  output  2  copy of request len
respstream_data  output  32  read data (zero-extended); 0 for writes

Behaviour:
- FSM states: IDLE, BUSY. Single outstanding request; no request queue.
- Reset (reset==0 at a clock edge): state=IDLE, latency counter=0, response registers cleared. reqstream_rdy=1 and respstream_val=0 from the first cycle after reset. Storage contents are not reset.
- IDLE:
  - reqstream_rdy=1 and respstream_val=0.
  - On reqstream_val && reqstream_rdy in cycle t: capture type, opaque, len, test and read data; commit any write; load counter with p_latency-1; go to BUSY.
- BUSY:
  - reqstream_rdy=0.
  - The counter decrements each cycle while nonzero.
  - respstream_val = (counter==0), so the first valid cycle is t+p_latency.
  - Response outputs are stable while respstream_val=1 and respstream_rdy=0.
  - On respstream_val && respstream_rdy: go to IDLE. The next request cannot be accepted before the following cycle, so throughput is 1 request per p_latency+1 cycles.
- Address decode:
  - word index = addr[log2(p_num_words)+1:2]; byte offset = addr[1:0].
  - Out of range when addr >= 4*p_num_words: test=1, read data=0, write suppressed.
- Length decode: nbytes = (len==0) ? 4 : len.
- Read: data = word >> (8*offset), masked to the low nbytes bytes, zero-extended.
- Write: byte k of reqstream_data goes to byte offset+k of the word, for k < nbytes and offset+k < 4. Bytes that would cross into the next word are dropped; no wrap into the next word.
- Reserved type (2..7): no storage access, data=0, test=2, response still returned.
- Read data is sampled in the accept cycle, before that cycle's write. A read that follows a write in a later transaction sees the new data.
- Reset asserted while in BUSY: the pending response is discarded and respstream_val=0 the next cycle. A write already committed at accept persists.
- reqstream_* inputs are ignored while reqstream_rdy=0.

Test Plan:
- p_latency=1: write addr 0x0000_0010 len 0 data 0xDEADBEEF opaque 0x05, accepted at cycle t -> respstream_val=1 at t+1 with type=1, opaque=0x05, test=0, data=0. Then read the same address -> data=0xDEADBEEF.
- Subword: write len=1 data 0xAB to addr 0x11 over word 0x11223344 -> word becomes 0x1122AB44. Read len=2 at addr 0x12 -> data=0x00001122.
- p_latency=3 with respstream_rdy held 0 for 4 cycles after valid -> val rises at t+3, outputs constant while stalled, reqstream_rdy=0 throughout, IDLE one cycle after the handshake.
- p_num_words=256: read addr 0x400 -> test=1, data=0. Write to 0x400 followed by a read of 0x0 -> word 0 unchanged.
- reset driven to 0 in the cycle after accept with p_latency=4 -> respstream_val never asserts, reqstream_rdy=1 the cycle after reset is released, and the earlier write is visible on a subsequent read.
- Back-to-back reads with respstream_rdy=1 and reqstream_val held 1, p_latency=2 -> accepts spaced 3 cycles apart and opaque values returned in order.
